fla_prog_seq: RTL and testbench
===============================

# fla_prog_seq

Flash program/erase initiator for mapper cores that keep PRG in a JEDEC-style parallel NOR flash. It accepts a single byte-program or sector-erase request from the save/host side. It issues the standard unlock command cycles on the flash bus (0x5555/0xAA, 0x2AAA/0x55, then the command), polls DQ7 until the operation completes, and reports done or timeout. It is the writer-side counterpart to the command-sequence decoders in the mappers, and is used for save-state and PRG-flash writeback without CPU involvement.

## Interface
- STB_CYC, 4: width of each WE/OE low pulse, in clk cycles (≥1).
- POLL_MAX, 16'hFFFF: number of DQ7 polls before a timeout is declared.
- clk  in  1  system clock; all logic on rising edge.
- map_rst_n  in  1  reset, synchronous and active-low; one clock; reset is synchronous and active-low.
- req  in  1  start pulse; sampled only while busy=0.
- req_ers  in  1  0 = byte program, 1 = sector erase; sampled with req.
- req_addr  in  19  target byte/sector address; sampled with req.
- req_dat  in  8  program data; sampled with req; ignored for erase.
- busy  out  1  high from the cycle after an accepted req until done/err is asserted.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout; asserted instead of done.
- fla_addr  out  19  flash address.
- fla_dout  out  8  flash write data.
- fla_din  in  8  flash read data.
- fla_ce  out  1  active-high chip select.
- fla_we  out  1  active-high write strobe.
- fla_oe  out  1  active-high read strobe.

## Operation
- Reset values: busy=0, done=0, err=0, fla_ce=0, fla_we=0, fla_oe=0, fla_addr=0, fla_dout=0. The state machine resets to IDLE and the poll counter to 0.
- Command lists. Unlock addresses are {req_addr[18:15], 15'h5555} and {req_addr[18:15], 15'h2AAA}, so the unlock stays in the target's 32 KB window.
  - Program, 4 cycles: 5555/AA, 2AAA/55, 5555/A0, req_addr/req_dat.
  - Erase, 6 cycles: 5555/AA, 2AAA/55, 5555/80, 5555/AA, 2AAA/55, req_addr/30.
- State machine:
  - IDLE: when req=1, latch all req_* fields, set idx=0, and go to SETUP.
  - SETUP, 1 clk: drive fla_addr and fla_dout from the list entry idx, with fla_ce=1 and fla_we=0. Then go to STROBE.
  - STROBE, STB_CYC clks: fla_we=1, with address and data held. Then go to HOLD.
  - HOLD, 1 clk: fla_we=0, address and data held. If idx is the last entry, go to PSETUP; otherwise increment idx and go to SETUP.
  - PSETUP, 1 clk: fla_addr=req_addr, fla_oe=0. Go to PREAD.
  - PREAD, STB_CYC clks: fla_oe=1. On the last cycle, register fla_din. Then go to PCHK.
  - PCHK, 1 clk: fla_oe=0. The operation is complete when DQ7 equals the target value: req_dat[7] for program, 1 for erase.
    - Complete: pulse done and go to IDLE.
    - Not complete and poll counter = POLL_MAX-1: go to ABORT.
    - Otherwise: increment the poll counter and go to PSETUP.
  - ABORT: issue one bus cycle 0x000000/F0 (read-reset) using the SETUP/STROBE/HOLD timing, then pulse err and go to IDLE.
- fla_ce is 1 in every state except IDLE.
- busy is 1 in every state except IDLE. It falls in the same cycle that done or err pulses.
- req while busy=1 is ignored; there is no queue.
- Reset mid-operation: map_rst_n=0 forces all outputs to their reset values on the next edge, with no read-reset cycle. The flash may be left in command mode, and the next accepted request proceeds normally.
- The poll counter is 16 bits and saturates logic at POLL_MAX-1; it never wraps.

## Timing
- Each write cycle takes STB_CYC+2 clks, so the write phase is 4·(STB_CYC+2) for program and 6·(STB_CYC+2) for erase.
- Each poll takes STB_CYC+2 clks.
- Best-case program latency (completes on the first poll), from the req edge to the done pulse: 1 + 5·(STB_CYC+2) clks. With the default STB_CYC=4 this is 31 clks.
- The WE rising edge occurs with address and data stable for 1 clk after it (the HOLD state). Address and data change only on SETUP entry.
- done and err are registered and mutually exclusive. A new req is accepted on the cycle after done or err.

## Structure
- A shared package `fla_pkg` holds:
  - the unlock constants 15'h5555 and 15'h2AAA;
  - the command bytes AA, 55, A0, 80, 30, F0;
  - the state enum;
  - the command-list length constants (4 and 6).
- One sub-module, `fla_cmd_rom`: combinational lookup of (ers, idx, req_addr, req_dat) → (addr, dat, last).
- The top level holds the FSM, the strobe counter and the poll counter.

## Test plan
- Program: req at addr 0x1_2345, data 0x5A, with a flash model whose DQ7 is inverted for 3 polls. Required response:
  - writes 0x15555/AA, 0x12AAA/55, 0x15555/A0, 0x12345/5A in order;
  - 4 polls, then a single done pulse at clk 1+4·6+4·6;
  - err=0.
- Erase: req_ers=1 at addr 0x4_0000, with the model ready on the first poll. Required response:
  - six writes, ending with 0x40000/30;
  - done at clk 1+7·6=43.
- Timeout: POLL_MAX=8, model never ready. Required response:
  - exactly 8 polls;
  - one write 0x00000/F0;
  - err pulse, with no done pulse.
- req pulsed continuously while busy: only the first request executes; busy is high throughout; exactly one done pulse.
- Reset mid-strobe: map_rst_n=0 during the third write's STROBE. Required response:
  - the next clk shows fla_we=0, fla_ce=0, busy=0;
  - a following program request completes normally.
- Write-cycle timing: with STB_CYC=1, every WE pulse is 1 clk wide, with fla_addr and fla_dout stable from 1 clk before the pulse to 1 clk after it.

Source files
------------

// File: rtl/fla_pkg.sv
// Shared constants and state encoding for the JEDEC flash program/erase sequencer.
package fla_pkg;
  localparam logic [14:0] UNLK_A = 15'h5555;
  localparam logic [14:0] UNLK_B = 15'h2AAA;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_F0 = 8'hF0;

  localparam int PRG_LEN = 4;
  localparam int ERS_LEN = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_PSETUP,
    S_PREAD,
    S_PCHK,
    S_ABORT
  } state_t;
endpackage

// File: rtl/fla_cmd_rom.sv
// Command-list lookup: maps (operation, step index) to the flash bus address/data of that write cycle.
module fla_cmd_rom
  import fla_pkg::*;
(
  input  logic        ers,
  input  logic [2:0]  idx,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_dat,
  output logic [18:0] addr,
  output logic [7:0]  dat,
  output logic        last
);
  logic [18:0] unlk_a;
  logic [18:0] unlk_b;

  // Unlock cycles stay inside the target's 32 KB window.
  assign unlk_a = {req_addr[18:15], UNLK_A};
  assign unlk_b = {req_addr[18:15], UNLK_B};

  always_comb begin
    addr = unlk_a;
    dat  = CMD_AA;
    last = 1'b0;
    if (!ers) begin
      case (idx)
        3'd0: ;
        3'd1: begin addr = unlk_b; dat = CMD_55; end
        3'd2: dat = CMD_A0;
        default: begin addr = req_addr; dat = req_dat; last = 1'b1; end
      endcase
    end else begin
      case (idx)
        3'd0: ;
        3'd1: begin addr = unlk_b; dat = CMD_55; end
        3'd2: dat = CMD_80;
        3'd3: ;
        3'd4: begin addr = unlk_b; dat = CMD_55; end
        default: begin addr = req_addr; dat = CMD_30; last = 1'b1; end
      endcase
    end
  end
endmodule

// File: rtl/fla_prog_seq.sv
// Flash byte-program / sector-erase initiator: unlock command cycles, DQ7 polling, done/timeout report.
module fla_prog_seq
  import fla_pkg::*;
#(
  parameter int STB_CYC  = 4,
  parameter int POLL_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        map_rst_n,
  input  logic        req,
  input  logic        req_ers,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_dat,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [18:0] fla_addr,
  output logic [7:0]  fla_dout,
  input  logic [7:0]  fla_din,
  output logic        fla_ce,
  output logic        fla_we,
  output logic        fla_oe
);
  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        ers_reg, ers_next;
  logic [18:0] addr_reg, addr_next;
  logic [7:0]  dat_reg, dat_next;
  logic [7:0]  stb_reg, stb_next;
  logic [15:0] poll_reg, poll_next;
  logic        abort_reg, abort_next;
  logic        dq7_reg, dq7_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic [18:0] rom_addr;
  logic [7:0]  rom_dat;
  logic        rom_last;
  logic        stb_last;
  logic        poll_last;
  logic        complete;

  fla_cmd_rom u_rom (
    .ers      (ers_reg),
    .idx      (idx_reg),
    .req_addr (addr_reg),
    .req_dat  (dat_reg),
    .addr     (rom_addr),
    .dat      (rom_dat),
    .last     (rom_last)
  );

  assign stb_last  = (stb_reg == 8'(STB_CYC - 1));
  assign poll_last = (poll_reg == 16'(POLL_MAX - 1));
  assign complete  = (dq7_reg == (ers_reg ? 1'b1 : dat_reg[7]));

  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      ers_reg   <= 1'b0;
      addr_reg  <= '0;
      dat_reg   <= '0;
      stb_reg   <= '0;
      poll_reg  <= '0;
      abort_reg <= 1'b0;
      dq7_reg   <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ers_reg   <= ers_next;
      addr_reg  <= addr_next;
      dat_reg   <= dat_next;
      stb_reg   <= stb_next;
      poll_reg  <= poll_next;
      abort_reg <= abort_next;
      dq7_reg   <= dq7_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ers_next   = ers_reg;
    addr_next  = addr_reg;
    dat_next   = dat_reg;
    stb_next   = stb_reg;
    poll_next  = poll_reg;
    abort_next = abort_reg;
    dq7_next   = dq7_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          ers_next   = req_ers;
          addr_next  = req_addr;
          dat_next   = req_dat;
          idx_next   = '0;
          poll_next  = '0;
          abort_next = 1'b0;
          state_next = S_SETUP;
        end
      end
      S_SETUP, S_ABORT: begin
        stb_next   = '0;
        state_next = S_STROBE;
      end
      S_STROBE: begin
        if (stb_last) state_next = S_HOLD;
        else          stb_next   = stb_reg + 8'd1;
      end
      S_HOLD: begin
        if (abort_reg) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else if (rom_last) begin
          state_next = S_PSETUP;
        end else begin
          idx_next   = idx_reg + 3'd1;
          state_next = S_SETUP;
        end
      end
      S_PSETUP: begin
        stb_next   = '0;
        state_next = S_PREAD;
      end
      S_PREAD: begin
        if (stb_last) begin
          dq7_next   = fla_din[7];
          state_next = S_PCHK;
        end else begin
          stb_next = stb_reg + 8'd1;
        end
      end
      S_PCHK: begin
        if (complete) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (poll_last) begin
          // Read-reset cycle reuses the write timing; abort_reg overrides the bus values.
          abort_next = 1'b1;
          state_next = S_ABORT;
        end else begin
          poll_next  = poll_reg + 16'd1;
          state_next = S_PSETUP;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // During polling idx stays on the last entry, whose address is req_addr.
  assign fla_addr = (state_reg == S_IDLE || abort_reg) ? 19'd0 : rom_addr;
  assign fla_dout = (state_reg == S_IDLE) ? 8'd0 : (abort_reg ? CMD_F0 : rom_dat);
  assign busy     = (state_reg != S_IDLE);
  assign fla_ce   = (state_reg != S_IDLE);
  assign fla_we   = (state_reg == S_STROBE);
  assign fla_oe   = (state_reg == S_PREAD);
  assign done     = done_reg;
  assign err      = err_reg;
endmodule

// File: tb/tb_fla_prog_seq.sv
// Self-checking bench for fla_prog_seq: table-driven operations with a write scoreboard and a DQ7 flash model.
module tb_fla_prog_seq;
  typedef struct {
    logic        ers;
    logic [18:0] addr;
    logic [7:0]  dat;
    int          ready;
    logic        hold;
    int          exp_polls;
    int          exp_clk;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_ers = 1'b0;
  logic [18:0] req_addr = '0;
  logic [7:0]  req_dat = '0;
  logic        busy, done, err, fla_ce, fla_we, fla_oe;
  logic [18:0] fla_addr;
  logic [7:0]  fla_dout, fla_din;

  logic        req1 = 1'b0;
  logic        busy1, done1, err1, fla_ce1, fla_we1, fla_oe1;
  logic [18:0] fla_addr1;
  logic [7:0]  fla_dout1;
  logic [7:0]  fla_din1 = 8'h80;

  int   mdl_polls = 0;
  int   mdl_ready = 0;
  logic mdl_tgt = 1'b0;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign fla_din = (mdl_polls < mdl_ready) ? {~mdl_tgt, 7'h15} : {mdl_tgt, 7'h2A};

  fla_prog_seq #(.STB_CYC(4), .POLL_MAX(8)) dut (
    .clk(clk), .map_rst_n(rst_n), .req(req), .req_ers(req_ers), .req_addr(req_addr),
    .req_dat(req_dat), .busy(busy), .done(done), .err(err), .fla_addr(fla_addr),
    .fla_dout(fla_dout), .fla_din(fla_din), .fla_ce(fla_ce), .fla_we(fla_we), .fla_oe(fla_oe)
  );

  fla_prog_seq #(.STB_CYC(1), .POLL_MAX(8)) dut1 (
    .clk(clk), .map_rst_n(rst_n), .req(req1), .req_ers(1'b0), .req_addr(19'h21234),
    .req_dat(8'hC3), .busy(busy1), .done(done1), .err(err1), .fla_addr(fla_addr1),
    .fla_dout(fla_dout1), .fla_din(fla_din1), .fla_ce(fla_ce1), .fla_we(fla_we1), .fla_oe(fla_oe1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [18:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic run_op(input vec_t v);
    logic [18:0] u1, u2;
    wr_t e;
    int n, nd;
    bit fin, busy_ok;
    logic we_p, oe_p;
    u1 = {v.addr[18:15], 15'h5555};
    u2 = {v.addr[18:15], 15'h2AAA};
    exp_q.delete();
    if (!v.ers) begin
      exp_q.push_back(mk(u1, 8'hAA)); exp_q.push_back(mk(u2, 8'h55));
      exp_q.push_back(mk(u1, 8'hA0)); exp_q.push_back(mk(v.addr, v.dat));
    end else begin
      exp_q.push_back(mk(u1, 8'hAA)); exp_q.push_back(mk(u2, 8'h55));
      exp_q.push_back(mk(u1, 8'h80)); exp_q.push_back(mk(u1, 8'hAA));
      exp_q.push_back(mk(u2, 8'h55)); exp_q.push_back(mk(v.addr, 8'h30));
    end
    if (v.exp_err) exp_q.push_back(mk(19'h0, 8'hF0));
    mdl_polls = 0;
    mdl_ready = v.ready;
    mdl_tgt   = v.ers ? 1'b1 : v.dat[7];
    @(negedge clk);
    req = 1'b1; req_ers = v.ers; req_addr = v.addr; req_dat = v.dat;
    n = 0; fin = 0; busy_ok = 1; we_p = 0; oe_p = 0;
    while (!fin && n < 3000) begin
      @(posedge clk); #1; n++;
      if (n == 1 && !v.hold) req = 1'b0;
      if (fla_we && !we_p) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 32'(fla_addr), 32'h7FFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(fla_addr), 32'(e.a));
          check("write_dat", 32'(fla_dout), 32'(e.d));
        end
      end
      if (!fla_oe && oe_p) mdl_polls++;
      we_p = fla_we;
      oe_p = fla_oe;
      if (done || err) begin
        fin = 1;
        req = 1'b0;
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    check("op_finished", 32'(fin), 32'd1);
    check("end_clk", 32'(n), 32'(v.exp_clk));
    check("err_flag", 32'(err), 32'(v.exp_err));
    check("done_flag", 32'(done), 32'(!v.exp_err));
    check("busy_at_end", 32'(busy), 32'd0);
    check("busy_throughout", 32'(busy_ok), 32'd1);
    check("poll_count", 32'(mdl_polls), 32'(v.exp_polls));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    $display("op ers=%0d addr=%05h dat=%02h hold=%0d -> end_clk=%0d polls=%0d err=%0d",
             v.ers, v.addr, v.dat, v.hold, n, mdl_polls, err);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || err || busy) nd++;
    end
    check("quiet_after_end", 32'(nd), 32'd0);
  endtask

  task automatic run_timing;
    logic we_h[3];
    logic [18:0] a_h[3];
    logic [7:0] d_h[3];
    int n, pulses;
    bit fin;
    for (int i = 0; i < 3; i++) begin we_h[i] = 0; a_h[i] = '0; d_h[i] = '0; end
    @(negedge clk);
    req1 = 1'b1;
    n = 0; pulses = 0; fin = 0;
    while (!fin && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == 1) req1 = 1'b0;
      we_h[0] = we_h[1]; a_h[0] = a_h[1]; d_h[0] = d_h[1];
      we_h[1] = we_h[2]; a_h[1] = a_h[2]; d_h[1] = d_h[2];
      we_h[2] = fla_we1; a_h[2] = fla_addr1; d_h[2] = fla_dout1;
      if (n >= 3 && we_h[1]) begin
        pulses++;
        check("we_width", 32'({we_h[0], we_h[2]}), 32'd0);
        check("addr_stable", 32'(a_h[0] == a_h[1] && a_h[1] == a_h[2]), 32'd1);
        check("dout_stable", 32'(d_h[0] == d_h[1] && d_h[1] == d_h[2]), 32'd1);
        $display("stb1 pulse %0d addr=%05h dout=%02h", pulses, a_h[1], d_h[1]);
      end
      if (done1 || err1) fin = 1;
    end
    check("stb1_done", 32'({done1, err1}), 32'b10);
    check("stb1_pulses", 32'(pulses), 32'd4);
    check("stb1_end_clk", 32'(n), 32'd16);
  endtask

  initial begin
    vecs[0] = '{1'b0, 19'h12345, 8'h5A, 3, 1'b0, 4, 49, 1'b0};
    vecs[1] = '{1'b1, 19'h40000, 8'h00, 0, 1'b0, 1, 43, 1'b0};
    vecs[2] = '{1'b0, 19'h78001, 8'h80, 1000, 1'b0, 8, 79, 1'b1};
    vecs[3] = '{1'b0, 19'h07FFF, 8'h00, 0, 1'b1, 1, 31, 1'b0};
    vecs[4] = '{1'b1, 19'h7FFFF, 8'hFF, 2, 1'b0, 3, 55, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_strobes", 32'({fla_ce, fla_we, fla_oe}), 32'd0);
    check("rst_addr", 32'(fla_addr), 32'd0);
    check("rst_dout", 32'(fla_dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Reset during the third write's strobe.
    begin
      int n, rises;
      logic we_p;
      mdl_polls = 0; mdl_ready = 0; mdl_tgt = 1'b0;
      @(negedge clk);
      req = 1'b1; req_ers = 1'b0; req_addr = 19'h12345; req_dat = 8'h5A;
      n = 0; rises = 0; we_p = 0;
      while (rises < 3 && n < 200) begin
        @(posedge clk); #1; n++;
        if (n == 1) req = 1'b0;
        if (fla_we && !we_p) rises++;
        we_p = fla_we;
      end
      check("rst_mid_reached", 32'(rises), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_we", 32'(fla_we), 32'd0);
      check("rst_mid_ce", 32'(fla_ce), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_addr", 32'(fla_addr), 32'd0);
      $display("reset mid-strobe: we=%0d ce=%0d busy=%0d", fla_we, fla_ce, busy);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_op(vecs[0]);

    run_timing();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
